// File: rtl/cpu_pkg.sv
// Shared RV32 constants, ALU-op enumeration and ALU helpers for the cpu_core slice.
package cpu_pkg;
    localparam int XLEN = 32;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    // alt selects SUB/SRA; callers only set it where funct7 legality was already checked
    function automatic alu_op_e alu_decode(logic [2:0] f3, logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] alu_eval(alu_op_e op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: return {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $signed(a) >>> b[4:0];
            ALU_OR:   return a | b;
            default:  return a & b;
        endcase
    endfunction
endpackage

// File: rtl/cpu_datapath.sv
// Decode, ALU and register file for one instruction per cycle.
// OP-IMM support is compiled in only when CPU_ITYPE_EN is defined.
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] instr
);
    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] rdata1, rdata2, opb, result;
    logic            wen;
    alu_op_e         op;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];

`ifdef CPU_ITYPE_EN
    logic [XLEN-1:0] imm;
    assign imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
`endif

    // Anything not matched leaves wen low, which is how unsupported words become NOPs.
    always_comb begin
        wen = 1'b0;
        op  = ALU_ADD;
        opb = rdata2;
        case (opcode)
            OP_R: begin
                if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))) begin
                    wen = 1'b1;
                    op  = alu_decode(f3, f7[5]);
                end
            end
`ifdef CPU_ITYPE_EN
            OP_IMM: begin
                opb = imm;
                op  = alu_decode(f3, f3 == F3_SR && f7[5]);
                if (f3 == F3_SLL)     wen = (f7 == F7_BASE);
                else if (f3 == F3_SR) wen = (f7 == F7_BASE || f7 == F7_ALT);
                else                  wen = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign result = alu_eval(op, rdata1, opb);

    // Reset suppresses the write so an aborted cycle leaves no trace.
    cpu_regfile rf (
        .clk    (clk),
        .we     (wen & reset),
        .waddr  (rd),
        .wdata  (result),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );
endmodule

// File: rtl/cpu_imem.sv
// Instruction memory: combinational word read, sync write port for loading.
module cpu_imem
    import cpu_pkg::*;
#(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);
    logic [XLEN-1:0] memory [0:WORDS-1];

    always_ff @(posedge clk) begin
        if (we) memory[waddr] <= wdata;
    end

    assign rdata = memory[raddr];
endmodule

// File: rtl/cpu_regfile.sv
// 32 x XLEN register file: two async read ports, one sync write port, x0 hardwired to zero.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);
    // No reset: contents persist across reset so preloads survive.
    logic [XLEN-1:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (we && waddr != 5'd0) regs[waddr] <= wdata;
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];
endmodule

// File: rtl/cpu_core.sv
// Single-cycle RV32 integer core (R-type; OP-IMM when CPU_ITYPE_EN is defined), no branches.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int          IMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic clk,
    input  logic reset
);
    localparam int          AW      = $clog2(IMEM_WORDS);
    localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1);

    logic [31:0]     pc;
    logic [XLEN-1:0] instr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= RESET_PC;
        else        pc <= (pc + 32'd4) & PC_MASK;
    end

    // Memory is loaded through the hierarchy; the write port stays idle.
    cpu_imem #(.WORDS(IMEM_WORDS)) imem0 (
        .clk   (clk),
        .we    (1'b0),
        .waddr ('0),
        .wdata ('0),
        .raddr (pc[AW+1:2]),
        .rdata (instr)
    );

    cpu_datapath dp0 (
        .clk   (clk),
        .reset (reset),
        .instr (instr)
    );
endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: expected register/PC values queued per step, popped after the edge.
module tb_cpu_core;
    logic clk;
    logic reset;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        int          sel;   // 0..31 register, 32 = PC
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    cpu_core #(.IMEM_WORDS(256), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(logic [6:0] f7, logic [2:0] f3, logic [4:0] rd,
                                          logic [4:0] rs1, logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(logic [11:0] imm, logic [2:0] f3, logic [4:0] rd,
                                          logic [4:0] rs1);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic exp_reg(input string tag, input int idx, input logic [31:0] v);
        sb.push_back('{tag, idx, v});
    endtask

    task automatic exp_pc(input string tag, input logic [31:0] v);
        sb.push_back('{tag, 32, v});
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = (e.sel == 32) ? dut.pc : dut.dp0.rf.regs[e.sel];
            chk(e.tag, got, e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 256; i++) dut.imem0.memory[i] = 32'h0;
        for (int i = 1; i < 32; i++)  dut.dp0.rf.regs[i] = 32'h0;
        dut.dp0.rf.regs[1]  = 32'd10;
        dut.dp0.rf.regs[2]  = 32'd20;
        dut.dp0.rf.regs[3]  = 32'h5555_5555;
        dut.dp0.rf.regs[5]  = 32'h1234_5678;
        dut.dp0.rf.regs[7]  = 32'd0;
        dut.dp0.rf.regs[8]  = 32'd1;
        dut.dp0.rf.regs[11] = 32'h0000_DEAD;
        dut.dp0.rf.regs[18] = 32'h0000_FFFF;
        dut.dp0.rf.regs[20] = 32'd33;
        dut.dp0.rf.regs[21] = 32'd77;

        dut.imem0.memory[0]  = rtype(7'h00, 3'b000, 3, 1, 2);    // ADD  x3,x1,x2
        dut.imem0.memory[1]  = rtype(7'h20, 3'b000, 4, 3, 1);    // SUB  x4,x3,x1
        dut.imem0.memory[2]  = rtype(7'h20, 3'b000, 9, 7, 8);    // SUB  x9,x7,x8
        dut.imem0.memory[3]  = rtype(7'h00, 3'b011, 10, 8, 9);   // SLTU x10,x8,x9
        dut.imem0.memory[4]  = rtype(7'h00, 3'b010, 11, 8, 9);   // SLT  x11,x8,x9
        dut.imem0.memory[5]  = rtype(7'h00, 3'b000, 0, 1, 2);    // ADD  x0,x1,x2
        dut.imem0.memory[6]  = rtype(7'h00, 3'b000, 12, 0, 1);   // ADD  x12,x0,x1
        dut.imem0.memory[7]  = 32'h0000_0000;
        dut.imem0.memory[8]  = itype(12'hFFF, 3'b000, 5, 0);     // ADDI x5,x0,-1
        dut.imem0.memory[9]  = rtype(7'h00, 3'b100, 13, 9, 1);   // XOR
        dut.imem0.memory[10] = rtype(7'h20, 3'b101, 14, 9, 8);   // SRA
        dut.imem0.memory[11] = rtype(7'h00, 3'b101, 15, 9, 8);   // SRL
        dut.imem0.memory[12] = rtype(7'h00, 3'b001, 16, 1, 8);   // SLL
        dut.imem0.memory[13] = rtype(7'h00, 3'b110, 17, 1, 2);   // OR
        dut.imem0.memory[14] = rtype(7'h00, 3'b111, 18, 1, 2);   // AND
        dut.imem0.memory[15] = rtype(7'h00, 3'b001, 19, 1, 20);  // SLL by 33 -> uses 1
        dut.imem0.memory[16] = rtype(7'h01, 3'b000, 21, 1, 2);   // MUL: unsupported
        dut.imem0.memory[17] = rtype(7'h20, 3'b111, 22, 1, 2);   // AND with alt f7: unsupported

        #1;
        chk("reset_pc", dut.pc, 32'h0);
        // edges while held in reset must not write or advance
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_pc("hold_pc", 32'h0);
        exp_reg("hold_x3", 3, 32'h5555_5555);
        drain();

        @(negedge clk);
        reset = 1'b1;
        exp_reg("add_x3", 3, 32'd30);          exp_pc("pc1", 32'd4);  step();
        exp_reg("sub_dep_x4", 4, 32'd20);      exp_pc("pc2", 32'd8);  step();
        exp_reg("sub_wrap_x9", 9, 32'hFFFF_FFFF); exp_pc("pc3", 32'd12); step();

        // mid-run reset: PC drops at once, registers untouched
        #2;
        reset = 1'b0;
        #1;
        exp_pc("async_rst_pc", 32'h0);
        exp_reg("rst_keep_x3", 3, 32'd30);
        exp_reg("rst_keep_x4", 4, 32'd20);
        exp_reg("rst_keep_x9", 9, 32'hFFFF_FFFF);
        drain();
        @(negedge clk);
        reset = 1'b1;

        exp_pc("restart_pc1", 32'd4);  exp_reg("restart_x3", 3, 32'd30); step();
        exp_pc("restart_pc2", 32'd8);  step();
        exp_pc("restart_pc3", 32'd12); step();

        // SLTU(1, 0xFFFFFFFF)=1 unsigned; SLT(1, -1)=0 signed
        exp_reg("sltu_x10", 10, 32'd1); step();
        exp_reg("slt_x11", 11, 32'd0);  step();
        exp_pc("pc_x0wr", 32'd24);      step();
        exp_reg("x0_reads_zero", 12, 32'd10); step();
        exp_pc("nop_pc", 32'd32);
        exp_reg("nop_keep_x3", 3, 32'd30);
        exp_reg("nop_keep_x12", 12, 32'd10);
        step();
`ifdef CPU_ITYPE_EN
        exp_reg("addi_x5", 5, 32'hFFFF_FFFF);
`else
        exp_reg("addi_nop_x5", 5, 32'h1234_5678);
`endif
        exp_pc("pc_addi", 32'd36);
        step();
        exp_reg("xor_x13", 13, 32'hFFFF_FFF5); step();
        exp_reg("sra_x14", 14, 32'hFFFF_FFFF); step();
        exp_reg("srl_x15", 15, 32'h7FFF_FFFF); step();
        exp_reg("sll_x16", 16, 32'd20);        step();
        exp_reg("or_x17", 17, 32'd30);         step();
        exp_reg("and_x18", 18, 32'd0);         step();
        exp_reg("shamt5_x19", 19, 32'd20);     step();
        exp_reg("mul_nop_x21", 21, 32'd77);    step();
        exp_reg("alt_and_nop_x22", 22, 32'd0); exp_pc("pc18", 32'd72); step();

        // run the remaining NOPs and confirm PC wraps to 0
        for (int i = 18; i < 255; i++) step();
        exp_pc("pc_wrap", 32'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
